// File: rtl/pj_bus_pkg.sv
// Shared definitions for the PJ bus responder: ack and size codes, type bits,
// FSM states and the line-burst length.
package pj_bus_pkg;

    localparam logic [1:0] ACK_NONE = 2'b00;
    localparam logic [1:0] ACK_OK   = 2'b01;
    localparam logic [1:0] ACK_ERR  = 2'b10;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam int TYPE_WRITE_BIT = 0;
    localparam int TYPE_BURST_BIT = 1;

    localparam int BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } pj_state_t;

    // Big-endian lanes: byte offset 0 lives in bits 31:24, i.e. enable bit 3.
    function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                                input logic [1:0] offset,
                                                input logic       burst);
        logic [3:0] be;
        be = 4'b1111;
        if (!burst) begin
            case (size)
                SIZE_BYTE: be = 4'b1000 >> offset;
                SIZE_HALF: be = offset[1] ? 4'b0011 : 4'b1100;
                default:   be = 4'b1111;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/pj_bus_resp_mem.sv
// Backing store for the PJ bus responder: byte-enabled synchronous write,
// registered read.
module pj_bus_resp_mem
    import pj_bus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pj_bus_resp.sv
// PJ bus target: single and 4-beat wrapping line transfers against a local
// memory, with programmable wait states and error/abort handling.
module pj_bus_resp
    import pj_bus_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pj_tv,
    input  logic        pj_ale,
    input  logic [29:0] pj_addr,
    input  logic [3:0]  pj_type,
    input  logic [1:0]  pj_size,
    input  logic [31:0] pj_data_out,
    output logic [31:0] pj_data_in,
    output logic [1:0]  pj_ack
);

    localparam int         ADDR_W    = $clog2(MEM_WORDS);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);
    localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

    pj_state_t         state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        ack_q, ack_d;

    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q, burst_q, err_q;

    logic              accept, req_err, err_d;
    logic [1:0]        cur_idx, next_idx;
    logic [ADDR_W-1:0] cur_word, next_word;

    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_raddr;
    logic [31:0]       mem_rdata;

    logic              unused_type_bits;
    assign unused_type_bits = ^pj_type[3:2];

    // Request checks are evaluated on the live inputs in the accepting cycle.
    always_comb begin
        req_err = ((pj_addr[29:2] >> ADDR_W) != 28'd0);
        if (!pj_type[TYPE_BURST_BIT]) begin
            case (pj_size)
                SIZE_HALF:    req_err = req_err | pj_addr[0];
                SIZE_WORD:    req_err = req_err | (pj_addr[1:0] != 2'b00);
                SIZE_ILLEGAL: req_err = 1'b1;
                default:      req_err = req_err;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pj_tv && pj_ale) begin
                    accept  = 1'b1;
                    wait_d  = '0;
                    beat_d  = '0;
                    state_d = NO_WAIT ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!pj_tv) begin
                    state_d = IDLE;
                    wait_d  = '0;
                    beat_d  = '0;
                end else if (wait_q == LAST_WAIT) begin
                    state_d = ACK;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ACK: begin
                wait_d = '0;
                if (pj_tv && burst_q && !err_q && beat_q != LAST_BEAT) begin
                    beat_d  = beat_q + 2'd1;
                    state_d = NO_WAIT ? ACK : WAIT;
                end else begin
                    beat_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
                beat_d  = '0;
            end
        endcase

        // With zero wait states the ack is decided in the accepting cycle itself.
        err_d = accept ? req_err : err_q;
        ack_d = (state_d == ACK) ? (err_d ? ACK_ERR : ACK_OK) : ACK_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            ack_q   <= ACK_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            ack_q   <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= pj_addr[ADDR_W+1:0];
            size_q  <= pj_size;
            write_q <= pj_type[TYPE_WRITE_BIT];
            burst_q <= pj_type[TYPE_BURST_BIT];
            err_q   <= req_err;
        end
    end

    // Critical word first: the beat index wraps inside the 16-byte line.
    always_comb begin
        cur_idx   = addr_q[3:2] + beat_q;
        next_idx  = addr_q[3:2] + beat_q + 2'd1;
        cur_word  = {addr_q[ADDR_W+1:4], cur_idx};
        next_word = {addr_q[ADDR_W+1:4], next_idx};
    end

    // The read port is aimed one cycle ahead of the beat that will be acked next.
    always_comb begin
        case (state_q)
            IDLE:    mem_raddr = pj_addr[ADDR_W+1:2];
            ACK:     mem_raddr = next_word;
            default: mem_raddr = cur_word;
        endcase
    end

    assign mem_we = (state_q == ACK) && write_q && !err_q && pj_tv;
    assign mem_be = lane_enables(size_q, addr_q[1:0], burst_q);

    pj_bus_resp_mem #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (cur_word),
        .wdata (pj_data_out),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign pj_ack     = ack_q;
    assign pj_data_in = (ack_q == ACK_OK && !write_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_pj_bus_resp.sv
// Self-checking bench for pj_bus_resp: table of single transfers plus
// hand-written burst, ignore, abort and reset sequences, scored by ack cycle.
module tb_pj_bus_resp;
    import pj_bus_pkg::*;

    localparam int MEM_WORDS = 1024;
    localparam int W         = 2;

    localparam logic [3:0] T_RD  = 4'b0000;
    localparam logic [3:0] T_WR  = 4'b0001;
    localparam logic [3:0] T_BRD = 4'b0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        pj_tv;
    logic        pj_ale;
    logic [29:0] pj_addr;
    logic [3:0]  pj_type;
    logic [1:0]  pj_size;
    logic [31:0] pj_data_out;
    logic [31:0] pj_data_in;
    logic [1:0]  pj_ack;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] data;
        bit          chk;
        int          cycle;
        int          tag;
    } exp_t;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  typ;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [1:0]  ack;
        logic [31:0] rdata;
        bit          chk;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    pj_bus_resp #(
        .MEM_WORDS   (MEM_WORDS),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pj_tv       (pj_tv),
        .pj_ale      (pj_ale),
        .pj_addr     (pj_addr),
        .pj_type     (pj_type),
        .pj_size     (pj_size),
        .pj_data_out (pj_data_out),
        .pj_data_in  (pj_data_in),
        .pj_ack      (pj_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int tag,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s tag=%0d got=%h want=%h (cycle %0d)", name, tag, actual, expected, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] ack, input logic [31:0] data,
                            input bit chk, input int cycle, input int tag);
        exp_t e;
        e.ack = ack; e.data = data; e.chk = chk; e.cycle = cycle; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Scores whatever the DUT shows in the current cycle against the queue.
    task automatic observe();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_ack tag=%0d got=none want=%b at cycle %0d", e.tag, e.ack, e.cycle);
        end
        if (pj_ack != ACK_NONE) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack got=%b data=%h want=none (cycle %0d)", pj_ack, pj_data_in, cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("ack_code", e.tag, {30'd0, pj_ack}, {30'd0, e.ack});
                checkOutput("ack_cycle", e.tag, cyc, e.cycle);
                if (e.chk) checkOutput("read_data", e.tag, pj_data_in, e.data);
            end
        end else begin
            checkOutput("idle_data", -1, pj_data_in, 32'd0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout got=%0d pending want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Presents one address phase and returns its cycle; address inputs are
    // scrambled afterwards so that only latched values can be used.
    task automatic applyStimulus(input logic [29:0] addr, input logic [3:0] typ,
                                 input logic [1:0] size, input logic [31:0] wdata,
                                 output int t0);
        t0          = cyc;
        pj_tv       = 1'b1;
        pj_ale      = 1'b1;
        pj_addr     = addr;
        pj_type     = typ;
        pj_size     = size;
        pj_data_out = wdata;
        step();
        pj_ale  = 1'b0;
        pj_addr = ~addr;
        pj_type = ~typ;
        pj_size = 2'b11;
    endtask

    task automatic add_vec(input logic [29:0] a, input logic [3:0] t, input logic [1:0] s,
                           input logic [31:0] wd, input logic [1:0] ak,
                           input logic [31:0] rd, input bit c);
        vec_t v;
        v.addr = a; v.typ = t; v.size = s; v.wdata = wd; v.ack = ak; v.rdata = rd; v.chk = c;
        vecs.push_back(v);
    endtask

    initial begin
        int t0;
        reset       = 1'b1;
        pj_tv       = 1'b0;
        pj_ale      = 1'b0;
        pj_addr     = '0;
        pj_type     = '0;
        pj_size     = '0;
        pj_data_out = '0;

        add_vec(30'h100,  T_WR,         SIZE_WORD,    32'hDEADBEEF, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h100,  T_RD,         SIZE_WORD,    32'h0,        ACK_OK,  32'hDEADBEEF, 1'b1);
        add_vec(30'h200,  T_WR,         SIZE_WORD,    32'h11223344, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h201,  T_WR,         SIZE_BYTE,    32'h005A0000, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h200,  T_RD,         SIZE_WORD,    32'h0,        ACK_OK,  32'h115A3344, 1'b1);
        add_vec(30'h203,  T_WR,         SIZE_HALF,    32'h0000FFFF, ACK_ERR, 32'h0,        1'b0);
        add_vec(30'h200,  T_RD,         SIZE_WORD,    32'h0,        ACK_OK,  32'h115A3344, 1'b1);
        add_vec(30'h1000, T_RD,         SIZE_WORD,    32'h0,        ACK_ERR, 32'h0,        1'b0);
        add_vec(30'h100,  T_RD,         SIZE_WORD,    32'h0,        ACK_OK,  32'hDEADBEEF, 1'b1);
        add_vec(30'h202,  4'b1101,      SIZE_HALF,    32'h0000ABCD, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h201,  T_RD,         SIZE_BYTE,    32'h0,        ACK_OK,  32'h115AABCD, 1'b1);
        add_vec(30'h206,  T_WR,         SIZE_WORD,    32'h0,        ACK_ERR, 32'h0,        1'b0);
        add_vec(30'h208,  T_WR,         SIZE_ILLEGAL, 32'h0,        ACK_ERR, 32'h0,        1'b0);
        add_vec(30'h208,  T_WR,         SIZE_WORD,    32'h01020304, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h20B,  T_WR,         SIZE_BYTE,    32'h000000EE, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h208,  T_WR,         SIZE_HALF,    32'h77880000, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h208,  T_RD,         SIZE_WORD,    32'h0,        ACK_OK,  32'h778803EE, 1'b1);
        add_vec(30'hFFC,  T_WR,         SIZE_WORD,    32'hCAFEF00D, ACK_OK,  32'h0,        1'b0);
        add_vec(30'hFFC,  T_RD,         SIZE_WORD,    32'h0,        ACK_OK,  32'hCAFEF00D, 1'b1);
        add_vec(30'h004,  T_WR,         SIZE_WORD,    32'h00000000, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h1004, T_WR,         SIZE_WORD,    32'h12345678, ACK_ERR, 32'h0,        1'b0);
        add_vec(30'h004,  T_RD,         SIZE_WORD,    32'h0,        ACK_OK,  32'h00000000, 1'b1);
        add_vec(30'h100,  T_WR,         SIZE_WORD,    32'hAAAA0001, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h104,  T_WR,         SIZE_WORD,    32'hBBBB0002, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h108,  T_WR,         SIZE_WORD,    32'hCCCC0003, ACK_OK,  32'h0,        1'b0);
        add_vec(30'h10C,  T_WR,         SIZE_WORD,    32'hDDDD0004, ACK_OK,  32'h0,        1'b0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        checkOutput("reset_ack", 0, {30'd0, pj_ack}, 32'd0);
        checkOutput("reset_data", 0, pj_data_in, 32'd0);
        step();

        $display("[TB] table of %0d single transfers, back to back", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].addr, vecs[i].typ, vecs[i].size, vecs[i].wdata, t0);
            push_exp(vecs[i].ack, vecs[i].rdata, vecs[i].chk, t0 + 1 + W, i);
            drain(40);
        end

        $display("[TB] burst read 0x108, critical word first");
        applyStimulus(30'h108, T_BRD, SIZE_WORD, 32'h0, t0);
        push_exp(ACK_OK, 32'hCCCC0003, 1'b1, t0 + 1 + W,           100);
        push_exp(ACK_OK, 32'hDDDD0004, 1'b1, t0 + 1 + W + (W + 1),  101);
        push_exp(ACK_OK, 32'hAAAA0001, 1'b1, t0 + 1 + W + 2*(W+1),  102);
        push_exp(ACK_OK, 32'hBBBB0002, 1'b1, t0 + 1 + W + 3*(W+1),  103);
        drain(60);

        $display("[TB] burst read 0x10E with byte size");
        applyStimulus(30'h10E, T_BRD, SIZE_BYTE, 32'h0, t0);
        push_exp(ACK_OK, 32'hDDDD0004, 1'b1, t0 + 1 + W,           110);
        push_exp(ACK_OK, 32'hAAAA0001, 1'b1, t0 + 1 + W + (W + 1),  111);
        push_exp(ACK_OK, 32'hBBBB0002, 1'b1, t0 + 1 + W + 2*(W+1),  112);
        push_exp(ACK_OK, 32'hCCCC0003, 1'b1, t0 + 1 + W + 3*(W+1),  113);
        drain(60);

        $display("[TB] ale without tv is ignored");
        pj_tv   = 1'b0;
        pj_ale  = 1'b1;
        pj_addr = 30'h100;
        pj_type = T_RD;
        pj_size = SIZE_WORD;
        step();
        pj_ale = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("[TB] ale during WAIT is ignored");
        applyStimulus(30'h104, T_RD, SIZE_WORD, 32'h0, t0);
        push_exp(ACK_OK, 32'hBBBB0002, 1'b1, t0 + 1 + W, 120);
        pj_ale  = 1'b1;
        pj_addr = 30'h108;
        pj_type = T_RD;
        step();
        pj_ale = 1'b0;
        drain(40);
        for (int i = 0; i < 6; i++) step();

        $display("[TB] burst aborted after beat 2");
        applyStimulus(30'h100, T_BRD, SIZE_WORD, 32'h0, t0);
        push_exp(ACK_OK, 32'hAAAA0001, 1'b1, t0 + 1 + W,          130);
        push_exp(ACK_OK, 32'hBBBB0002, 1'b1, t0 + 1 + W + (W + 1), 131);
        drain(40);
        pj_tv = 1'b0;
        step();
        applyStimulus(30'h108, T_RD, SIZE_WORD, 32'h0, t0);
        push_exp(ACK_OK, 32'hCCCC0003, 1'b1, t0 + 1 + W, 132);
        drain(40);
        for (int i = 0; i < 8; i++) step();

        $display("[TB] reset asserted during WAIT");
        applyStimulus(30'h104, T_RD, SIZE_WORD, 32'h0, t0);
        reset = 1'b1;
        step();
        checkOutput("midreset_ack", 140, {30'd0, pj_ack}, 32'd0);
        checkOutput("midreset_data", 140, pj_data_in, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        applyStimulus(30'h10C, T_RD, SIZE_WORD, 32'h0, t0);
        push_exp(ACK_OK, 32'hDDDD0004, 1'b1, t0 + 1 + W, 141);
        drain(40);

        pj_tv = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pj_bus_resp.md
PJ_BUS_RESP -- requirements
Module: pj_bus_resp

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the backing store (power of 2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each data beat (0..15).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pj_tv  input  1  transfer valid; held high by the initiator from address phase through the final ack.
REQ-006 pj_ale  input  1  address latch enable; one-cycle pulse marking the start of a transfer.
REQ-007 pj_addr  input  30  byte address; big-endian (byte 0 = bits 31:24).
REQ-008 pj_type  input  4  bit0 = write (1) / read (0); bit1 = 4-beat line burst; bits 3:2 = ignored.
REQ-009 pj_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-010 pj_data_out  input  32  write data from the initiator.
REQ-011 pj_data_in  output  32  read data returned to the initiator.
REQ-012 pj_ack  output  2  00 = none, 01 = beat done OK, 10 = error (terminates the transfer), 11 = never driven.

Function
REQ-013 SHALL implement states IDLE, WAIT, ACK.
- IDLE -> WAIT on pj_tv & pj_ale.
- WAIT -> ACK when the wait counter reaches WAIT_CYCLES.
- ACK -> WAIT if burst beats remain, else -> IDLE.
REQ-014 SHALL latch pj_addr, pj_type and pj_size in the IDLE cycle that accepts pj_ale; later changes on these inputs are ignored.
REQ-015 Latency: pj_ale accepted in cycle T -> first pj_ack in cycle T+1+WAIT_CYCLES; each later burst beat acks exactly WAIT_CYCLES+1 cycles after the previous one.
REQ-016 pj_ack and pj_data_in SHALL be registered; each SHALL be nonzero only in the ACK cycle, otherwise 0.
REQ-017 Single transfer: exactly one ack beat.
REQ-018 Burst transfer:
- exactly 4 beats;
- word index = (latched addr[3:2] + beat) mod 4, critical word first with wrap inside the 16-byte line;
- pj_size is ignored for bursts (word transfers).
REQ-019 Read: pj_data_in SHALL carry the full aligned word at the beat address; the initiator selects bytes.
REQ-020 Write:
- pj_data_out is sampled in the ACK cycle;
- byte lanes: byte -> lane addr[1:0]; half -> lanes addr[1]*2..+1; word -> all lanes.
REQ-021 Error (single 10 ack in cycle T+1+WAIT_CYCLES, then IDLE, no memory write) SHALL occur on any of:
- word address >= MEM_WORDS;
- pj_size = 11;
- halfword with addr[0] = 1;
- word with addr[1:0] != 0.
REQ-022 If pj_tv is low in any non-IDLE cycle, the transfer is aborted:
- return to IDLE next cycle;
- no further acks;
- beats already written remain.
REQ-023 pj_ale without pj_tv, or pj_ale outside IDLE, SHALL be ignored.
REQ-024 A new pj_ale SHALL be accepted in the cycle immediately after the final ack (back-to-back transfers).

Reset
REQ-025 reset SHALL force state IDLE, counters to 0, pj_ack = 00 and pj_data_in = 0 on the next edge, including mid-transfer; memory contents are not reset.

Structure
REQ-026 The shared package pj_bus_pkg SHALL hold:
- ack codes (ACK_NONE, ACK_OK, ACK_ERR);
- size codes;
- type bit positions;
- state enum;
- BURST_LEN = 4.
REQ-027 The storage SHALL be one sub-module, pj_bus_resp_mem: MEM_WORDS x 32, synchronous write with 4 byte enables, registered read.

Verification
REQ-028 WAIT_CYCLES = 2; word write 0xDEADBEEF to 0x100, then word read of 0x100 -> pj_ack = 01 at T+3 for each transfer, read data 0xDEADBEEF.
REQ-029 Burst read at 0x0108 with words 0x100..0x10C preloaded A, B, C, D -> four 01 acks 3 cycles apart returning C, D, A, B.
REQ-030 Byte write 0x5A to 0x201 over word 0x11223344 -> readback 0x115A3344; halfword write to 0x203 -> single 10 ack, word unchanged.
REQ-031 Address 0x1000 (MEM_WORDS = 1024) read -> 10 ack at T+3; next pj_ale in the following cycle -> accepted.
REQ-032 Aborts:
- burst, pj_tv dropped after beat 2 -> no further acks, IDLE next cycle;
- reset asserted in WAIT -> pj_ack = 00, IDLE, and a new transfer completes normally.
